// File: rtl/i2c_target_rsp.sv
`timescale 1ns/1ps
// i2c_target_rsp
// I2C target (responder) sitting at the far end of an I2C bus. SCL/SDA are
// oversampled on clk_i, START/STOP/repeated START are decoded, and the 7-bit
// address is matched against TARGET_ADDR. Master writes are always ACKed and
// each byte is presented on a one-cycle wr_valid_o strobe. Master reads are
// served from a request/ack fetch port. SDA is open-drain (0 = pull low,
// 1 = release) and SCL is never stretched.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous reset, active high
//   scl_i, sda_i   I2C bus inputs (asynchronous)
//   sda_o          SDA drive, 0 pulls low, 1 releases
//   start_o        pulse: addressed START/rep-START matched and ACKed
//   stop_o         pulse: STOP seen while busy
//   rw_o           direction of current addressed transfer (1 = read)
//   wr_valid_o     pulse: wr_data_o holds a freshly received byte
//   wr_data_o      last received write byte
//   rd_req_o       level: next read byte wanted
//   rd_ack_i       rd_data_i valid, completes the rd_req_o handshake
//   rd_data_i      byte to transmit
//   rd_underrun_o  pulse: no byte supplied in time, 8'hFF sent instead
//   busy_o         high from addressed START until STOP/mismatch/NACK
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | bus free or after STOP
// ADDR     | shifting in address byte
// ADDR_ACK | driving address ACK; 9th rise latches rw and raises busy
// WR_DATA  | shifting in a write byte
// WR_ACK   | driving ACK for a write byte
// RD_DATA  | driving a read byte MSB first
// RD_MACK  | releasing SDA, sampling master ACK/NACK
// IGNORE   | not addressed (or NACKed); wait for START/STOP
module i2c_target_rsp #(
  parameter int                    ADDR_WIDTH  = 7,
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR = 7'h22,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_o,
  output logic                  start_o,
  output logic                  stop_o,
  output logic                  rw_o,
  output logic                  wr_valid_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  rd_req_o,
  input  logic                  rd_ack_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  rd_underrun_o,
  output logic                  busy_o
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] FULL_CNT = 4'(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_MACK,
    S_IGNORE
  } state_t;

  // synchronizers and edge-detect flops
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;

  state_t                 r_state;
  logic [DATA_WIDTH-1:0]  r_shift;
  logic [3:0]             r_bit_cnt;
  // ACK phase: 0 wait first fall, 1 driving/waiting 9th rise, 2 wait final fall
  logic [1:0]             r_phase;
  logic                   r_sda_o;
  logic                   r_start;
  logic                   r_stop;
  logic                   r_rw;
  logic                   r_wr_valid;
  logic [DATA_WIDTH-1:0]  r_wr_data;
  logic                   r_rd_req;
  logic                   r_rd_have;
  logic [DATA_WIDTH-1:0]  r_rd_buf;
  logic                   r_underrun;
  logic                   r_busy;

  state_t                 w_state_nxt;
  logic [DATA_WIDTH-1:0]  w_shift_nxt;
  logic [3:0]             w_bit_cnt_nxt;
  logic [1:0]             w_phase_nxt;
  logic                   w_sda_o_nxt;
  logic                   w_start_nxt;
  logic                   w_stop_nxt;
  logic                   w_rw_nxt;
  logic                   w_wr_valid_nxt;
  logic [DATA_WIDTH-1:0]  w_wr_data_nxt;
  logic                   w_rd_req_nxt;
  logic                   w_rd_have_nxt;
  logic [DATA_WIDTH-1:0]  w_rd_buf_nxt;
  logic                   w_underrun_nxt;
  logic                   w_busy_nxt;

  logic                   w_scl;
  logic                   w_sda;
  logic                   w_scl_rise;
  logic                   w_scl_fall;
  logic                   w_start_evt;
  logic                   w_stop_evt;
  logic [DATA_WIDTH-1:0]  w_byte;
  logic                   w_addr_match;
  logic                   w_rd_take;
  logic                   w_load_ok;
  logic [DATA_WIDTH-1:0]  w_load_data;

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // SCL must be high on both sides of the SDA edge to count as START/STOP
  assign w_start_evt = w_scl & r_scl_d & ~w_sda & r_sda_d;
  assign w_stop_evt  = w_scl & r_scl_d & w_sda & ~r_sda_d;

  // byte as it will look once the bit currently on the bus is shifted in
  assign w_byte       = {r_shift[DATA_WIDTH-2:0], w_sda};
  assign w_addr_match = (w_byte[DATA_WIDTH-1 -: ADDR_WIDTH] == TARGET_ADDR);

  // an ack arriving on the load cycle itself still supplies the byte
  assign w_rd_take   = r_rd_req & rd_ack_i;
  assign w_load_ok   = r_rd_have | w_rd_take;
  assign w_load_data = r_rd_have ? r_rd_buf :
                       (w_rd_take ? rd_data_i : {DATA_WIDTH{1'b1}});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_phase    <= '0;
      r_sda_o    <= 1'b1;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_rw       <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_data  <= '0;
      r_rd_req   <= 1'b0;
      r_rd_have  <= 1'b0;
      r_rd_buf   <= '0;
      r_underrun <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_phase    <= w_phase_nxt;
      r_sda_o    <= w_sda_o_nxt;
      r_start    <= w_start_nxt;
      r_stop     <= w_stop_nxt;
      r_rw       <= w_rw_nxt;
      r_wr_valid <= w_wr_valid_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_rd_req   <= w_rd_req_nxt;
      r_rd_have  <= w_rd_have_nxt;
      r_rd_buf   <= w_rd_buf_nxt;
      r_underrun <= w_underrun_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_phase_nxt    = r_phase;
    w_sda_o_nxt    = r_sda_o;
    w_start_nxt    = 1'b0;
    w_stop_nxt     = 1'b0;
    w_rw_nxt       = r_rw;
    w_wr_valid_nxt = 1'b0;
    w_wr_data_nxt  = r_wr_data;
    w_rd_req_nxt   = r_rd_req;
    w_rd_have_nxt  = r_rd_have;
    w_rd_buf_nxt   = r_rd_buf;
    w_underrun_nxt = 1'b0;
    w_busy_nxt     = r_busy;

    // fetch handshake runs independently of bus state
    if (w_rd_take) begin
      w_rd_req_nxt  = 1'b0;
      w_rd_have_nxt = 1'b1;
      w_rd_buf_nxt  = rd_data_i;
    end

    if (w_start_evt) begin
      w_state_nxt   = S_ADDR;
      w_bit_cnt_nxt = '0;
      w_phase_nxt   = '0;
      w_sda_o_nxt   = 1'b1;
      w_rd_req_nxt  = 1'b0;
      w_rd_have_nxt = 1'b0;
    end else if (w_stop_evt) begin
      w_state_nxt   = S_IDLE;
      w_sda_o_nxt   = 1'b1;
      w_stop_nxt    = r_busy;
      w_busy_nxt    = 1'b0;
      w_rd_req_nxt  = 1'b0;
      w_rd_have_nxt = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte;
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            if (r_bit_cnt == LAST_BIT) begin
              w_bit_cnt_nxt = '0;
              w_phase_nxt   = '0;
              if (w_addr_match) begin
                w_state_nxt = S_ADDR_ACK;
              end else begin
                w_state_nxt = S_IGNORE;
                w_busy_nxt  = 1'b0;
              end
            end
          end
        end

        S_ADDR_ACK: begin
          if (w_scl_fall && r_phase == 2'd0) begin
            w_sda_o_nxt = 1'b0;
            w_phase_nxt = 2'd1;
          end else if (w_scl_rise && r_phase == 2'd1) begin
            w_phase_nxt  = 2'd2;
            w_rw_nxt     = r_shift[0];
            w_busy_nxt   = 1'b1;
            w_start_nxt  = 1'b1;
            if (r_shift[0]) begin
              w_rd_req_nxt = 1'b1;
            end
          end else if (w_scl_fall && r_phase == 2'd2) begin
            w_bit_cnt_nxt = '0;
            w_phase_nxt   = '0;
            if (r_rw) begin
              w_state_nxt    = S_RD_DATA;
              w_sda_o_nxt    = w_load_data[DATA_WIDTH-1];
              w_shift_nxt    = {w_load_data[DATA_WIDTH-2:0], 1'b1};
              w_underrun_nxt = ~w_load_ok;
              w_rd_req_nxt   = 1'b0;
              w_rd_have_nxt  = 1'b0;
            end else begin
              w_state_nxt = S_WR_DATA;
              w_sda_o_nxt = 1'b1;
            end
          end
        end

        S_WR_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte;
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            if (r_bit_cnt == LAST_BIT) begin
              w_wr_data_nxt  = w_byte;
              w_wr_valid_nxt = 1'b1;
              w_state_nxt    = S_WR_ACK;
              w_bit_cnt_nxt  = '0;
              w_phase_nxt    = '0;
            end
          end
        end

        S_WR_ACK: begin
          if (w_scl_fall && r_phase == 2'd0) begin
            w_sda_o_nxt = 1'b0;
            w_phase_nxt = 2'd1;
          end else if (w_scl_rise && r_phase == 2'd1) begin
            w_phase_nxt = 2'd2;
          end else if (w_scl_fall && r_phase == 2'd2) begin
            w_sda_o_nxt   = 1'b1;
            w_state_nxt   = S_WR_DATA;
            w_bit_cnt_nxt = '0;
            w_phase_nxt   = '0;
          end
        end

        S_RD_DATA: begin
          // bit_cnt counts bits already clocked out to the master
          if (w_scl_rise && r_bit_cnt != FULL_CNT) begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bit_cnt == FULL_CNT) begin
              w_sda_o_nxt   = 1'b1;
              w_state_nxt   = S_RD_MACK;
              w_bit_cnt_nxt = '0;
              w_phase_nxt   = '0;
            end else begin
              w_sda_o_nxt = r_shift[DATA_WIDTH-1];
              w_shift_nxt = {r_shift[DATA_WIDTH-2:0], 1'b1};
            end
          end
        end

        S_RD_MACK: begin
          if (w_scl_rise && r_phase == 2'd0) begin
            if (!w_sda) begin
              w_rd_req_nxt = 1'b1;
              w_phase_nxt  = 2'd1;
            end else begin
              w_busy_nxt  = 1'b0;
              w_state_nxt = S_IGNORE;
            end
          end else if (w_scl_fall && r_phase == 2'd1) begin
            w_state_nxt    = S_RD_DATA;
            w_bit_cnt_nxt  = '0;
            w_phase_nxt    = '0;
            w_sda_o_nxt    = w_load_data[DATA_WIDTH-1];
            w_shift_nxt    = {w_load_data[DATA_WIDTH-2:0], 1'b1};
            w_underrun_nxt = ~w_load_ok;
            w_rd_req_nxt   = 1'b0;
            w_rd_have_nxt  = 1'b0;
          end
        end

        S_IGNORE: begin
          w_sda_o_nxt = 1'b1;
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign sda_o         = r_sda_o;
  assign start_o       = r_start;
  assign stop_o        = r_stop;
  assign rw_o          = r_rw;
  assign wr_valid_o    = r_wr_valid;
  assign wr_data_o     = r_wr_data;
  assign rd_req_o      = r_rd_req;
  assign rd_underrun_o = r_underrun;
  assign busy_o        = r_busy;

endmodule

// File: tb/tb_i2c_target_rsp.sv
`timescale 1ns/1ps
module tb_i2c_target_rsp;

  localparam int Q = 4;  // quarter SCL period in clk cycles (high/low = 8 clk)

  logic       clk;
  logic       rst;
  logic       scl;
  logic       m_sda;
  logic       rd_ack;
  logic [7:0] rd_data;
  logic       rd_en;

  logic       sda_o;
  logic       start_o;
  logic       stop_o;
  logic       rw_o;
  logic       wr_valid_o;
  logic [7:0] wr_data_o;
  logic       rd_req_o;
  logic       rd_underrun_o;
  logic       busy_o;
  logic       w_bus;

  assign w_bus = m_sda & sda_o;

  i2c_target_rsp #(
    .ADDR_WIDTH (7),
    .DATA_WIDTH (8),
    .TARGET_ADDR(7'h22),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .scl_i        (scl),
    .sda_i        (w_bus),
    .sda_o        (sda_o),
    .start_o      (start_o),
    .stop_o       (stop_o),
    .rw_o         (rw_o),
    .wr_valid_o   (wr_valid_o),
    .wr_data_o    (wr_data_o),
    .rd_req_o     (rd_req_o),
    .rd_ack_i     (rd_ack),
    .rd_data_i    (rd_data),
    .rd_underrun_o(rd_underrun_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // event counters, written only by the monitor
  int         c_start, c_stop, c_wr, c_req, c_under, c_low;
  logic       p_req;
  logic [7:0] wr_log [0:15];

  initial begin
    c_start = 0; c_stop = 0; c_wr = 0; c_req = 0; c_under = 0; c_low = 0;
    p_req = 1'b0;
    for (int i = 0; i < 16; i++) wr_log[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (start_o) c_start++;
      if (stop_o) c_stop++;
      if (rd_underrun_o) c_under++;
      if (!sda_o) c_low++;
      if (rd_req_o && !p_req) c_req++;
      p_req = rd_req_o;
      if (wr_valid_o) begin
        wr_log[c_wr % 16] = wr_data_o;
        c_wr++;
      end
    end
  end

  // read-byte supplier: acks once rd_req_o has been up for 3 cycles
  logic [7:0] rd_vals [0:7];
  int         rd_idx;
  int         age;
  initial begin
    rd_vals[0] = 8'h64; rd_vals[1] = 8'h65; rd_vals[2] = 8'h5A; rd_vals[3] = 8'h3C;
    rd_vals[4] = 8'hC3; rd_vals[5] = 8'h11; rd_vals[6] = 8'h22; rd_vals[7] = 8'h33;
    rd_ack = 1'b0; rd_data = 8'h00; rd_idx = 0; age = 0;
    forever begin
      @(posedge clk); #1;
      if (rd_en && rd_req_o && !rst && age >= 3) begin
        rd_ack  = 1'b1;
        rd_data = rd_vals[rd_idx % 8];
        rd_idx++;
      end else begin
        rd_ack = 1'b0;
      end
      age = (rd_req_o && !rd_ack) ? age + 1 : 0;
    end
  end

  int n_vec, n_err;
  int s_start, s_stop, s_wr, s_req, s_under, s_low;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_start = c_start; s_stop = c_stop; s_wr = c_wr;
    s_req = c_req; s_under = c_under; s_low = c_low;
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_bit(input logic b, output logic s);
    wclk(Q); m_sda = b;
    wclk(Q); scl = 1'b1;
    wclk(Q); s = w_bus;
    wclk(Q); scl = 1'b0;
  endtask

  task automatic i2c_start();
    wclk(Q); m_sda = 1'b1;
    wclk(Q); scl = 1'b1;
    wclk(Q); m_sda = 1'b0;
    wclk(Q); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wclk(Q); m_sda = 1'b0;
    wclk(Q); scl = 1'b1;
    wclk(Q); m_sda = 1'b1;
    wclk(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
    i2c_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, s);
      d[i] = s;
    end
    i2c_bit(nack, s);
  endtask

  logic       ack;
  logic       s;
  logic [7:0] d;

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; scl = 1'b1; m_sda = 1'b1; rd_en = 1'b0;
    wclk(4);
    chk("rst sda_o", 32'(sda_o), 32'd1);
    chk("rst outs", {25'd0, start_o, stop_o, rw_o, wr_valid_o, rd_req_o, rd_underrun_o, busy_o}, 32'd0);
    chk("rst wr_data", 32'(wr_data_o), 32'd0);
    rst = 1'b0;
    wclk(4);

    // 1: write 0x00..0x03
    snap();
    i2c_start();
    send_byte(8'h44, ack);
    chk("t1 addr ack", 32'(ack), 32'd0);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'(i), ack);
      chk("t1 data ack", 32'(ack), 32'd0);
    end
    chk("t1 rw", 32'(rw_o), 32'd0);
    chk("t1 busy", 32'(busy_o), 32'd1);
    chk("t1 start cnt", 32'(c_start - s_start), 32'd1);
    chk("t1 wr cnt", 32'(c_wr - s_wr), 32'd4);
    for (int i = 0; i < 4; i++) chk("t1 wr data", 32'(wr_log[(s_wr + i) % 16]), 32'(i));
    i2c_stop();
    chk("t1 stop cnt", 32'(c_stop - s_stop), 32'd1);
    chk("t1 busy end", 32'(busy_o), 32'd0);

    // 2: read 0x64, 0x65 with ACK then NACK
    snap();
    rd_en = 1'b1;
    i2c_start();
    send_byte(8'h45, ack);
    chk("t2 addr ack", 32'(ack), 32'd0);
    chk("t2 rw", 32'(rw_o), 32'd1);
    recv_byte(1'b0, d);
    chk("t2 byte0", 32'(d), 32'h64);
    recv_byte(1'b1, d);
    chk("t2 byte1", 32'(d), 32'h65);
    chk("t2 busy after nack", 32'(busy_o), 32'd0);
    chk("t2 req rises", 32'(c_req - s_req), 32'd2);
    chk("t2 underrun", 32'(c_under - s_under), 32'd0);
    i2c_stop();
    chk("t2 stop cnt", 32'(c_stop - s_stop), 32'd0);

    // 3: address mismatch
    snap();
    i2c_start();
    send_byte(8'h46, ack);
    chk("t3 addr nack", 32'(ack), 32'd1);
    send_byte(8'hA5, ack);
    chk("t3 data nack", 32'(ack), 32'd1);
    chk("t3 sda low cycles", 32'(c_low - s_low), 32'd0);
    chk("t3 start cnt", 32'(c_start - s_start), 32'd0);
    chk("t3 wr cnt", 32'(c_wr - s_wr), 32'd0);
    chk("t3 req cnt", 32'(c_req - s_req), 32'd0);
    chk("t3 busy", 32'(busy_o), 32'd0);
    i2c_stop();
    chk("t3 stop cnt", 32'(c_stop - s_stop), 32'd0);

    // 4: write 0x10, repeated START, read one byte
    snap();
    i2c_start();
    send_byte(8'h44, ack);
    chk("t4 addr ack", 32'(ack), 32'd0);
    send_byte(8'h10, ack);
    chk("t4 data ack", 32'(ack), 32'd0);
    chk("t4 rw write", 32'(rw_o), 32'd0);
    i2c_start();
    send_byte(8'h45, ack);
    chk("t4 rd addr ack", 32'(ack), 32'd0);
    chk("t4 rw read", 32'(rw_o), 32'd1);
    recv_byte(1'b1, d);
    chk("t4 rd byte", 32'(d), 32'h5A);
    i2c_stop();
    chk("t4 start cnt", 32'(c_start - s_start), 32'd2);
    chk("t4 wr cnt", 32'(c_wr - s_wr), 32'd1);
    chk("t4 wr data", 32'(wr_log[s_wr % 16]), 32'h10);

    // 5: read underrun, then a supplied byte
    snap();
    rd_en = 1'b0;
    i2c_start();
    send_byte(8'h45, ack);
    chk("t5 addr ack", 32'(ack), 32'd0);
    recv_byte(1'b0, d);
    chk("t5 underrun byte", 32'(d), 32'hFF);
    chk("t5 underrun cnt", 32'(c_under - s_under), 32'd1);
    rd_en = 1'b1;
    recv_byte(1'b1, d);
    chk("t5 next byte", 32'(d), 32'h3C);
    chk("t5 underrun cnt2", 32'(c_under - s_under), 32'd1);
    i2c_stop();

    // 6: reset during 4th data bit of a read (0xC3 -> 4th bit is 0)
    i2c_start();
    send_byte(8'h45, ack);
    chk("t6 addr ack", 32'(ack), 32'd0);
    for (int i = 0; i < 3; i++) i2c_bit(1'b1, s);
    wclk(Q);
    chk("t6 sda before rst", 32'(sda_o), 32'd0);
    rst = 1'b1;
    wclk(1);
    chk("t6 sda after rst", 32'(sda_o), 32'd1);
    chk("t6 outs after rst", {25'd0, start_o, stop_o, rw_o, wr_valid_o, rd_req_o, rd_underrun_o, busy_o}, 32'd0);
    wclk(2);
    rst = 1'b0;
    wclk(4);
    snap();
    i2c_start();
    send_byte(8'h44, ack);
    chk("t6 re addr ack", 32'(ack), 32'd0);
    chk("t6 re busy", 32'(busy_o), 32'd1);
    send_byte(8'h77, ack);
    chk("t6 re data ack", 32'(ack), 32'd0);
    i2c_stop();
    chk("t6 re wr data", 32'(wr_log[s_wr % 16]), 32'h77);
    chk("t6 re counts", {8'(c_start - s_start), 8'(c_wr - s_wr), 8'(c_stop - s_stop), 8'd0}, 32'h01010100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
